// File: rtl/vga_pixel_feed_ctrl.sv
// Pixel feed between the upstream byte stream and the VGA timing block.
// A small FWFT FIFO is preloaded, aligned to vsync, and blanked to a fallback colour after an underrun.
module vga_pixel_feed_ctrl #(
  parameter int          DEPTH            = 16,
  parameter int          PRELOAD          = 12,
  parameter int          PIXELS_PER_FRAME = 307200,
  parameter logic [7:0]  FALLBACK         = 8'hE3
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [7:0]               data_in,
  input  logic                     data_valid,
  output logic                     data_ready,
  input  logic                     pixel_req,
  input  logic                     vsync,
  output logic [7:0]               rgb_out,
  output logic                     resync,
  output logic                     streaming,
  output logic                     underrun,
  output logic [7:0]               underrun_cnt,
  output logic [$clog2(DEPTH):0]   fifo_level
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  localparam int CW = $clog2(PIXELS_PER_FRAME);

  typedef enum logic [1:0] {FILL, ARMED, STREAM, FLUSH} state_t;

  state_t          state;
  logic [7:0]      mem [DEPTH];
  logic [AW-1:0]   rd_ptr;
  logic [AW-1:0]   wr_ptr;
  logic [CW-1:0]   pix_cnt;
  logic            frame_bad;

  logic            full;
  logic            empty;
  logic            push;
  logic            pop;
  logic            stream_req;
  logic            miss;
  logic            frame_end;
  logic [LW-1:0]   level_next;

  assign full       = (fifo_level == LW'(DEPTH));
  assign empty      = (fifo_level == '0);
  assign push       = data_valid && data_ready;
  assign stream_req = (state == STREAM) && pixel_req;
  assign pop        = stream_req && !frame_bad && !empty;
  assign miss       = stream_req && !frame_bad && empty;
  assign frame_end  = stream_req && (pix_cnt == CW'(PIXELS_PER_FRAME - 1));
  assign level_next = fifo_level + LW'(push) - LW'(pop);
  assign streaming  = (state == STREAM);

  // Ready reflects fullness at the start of the cycle, so a pop never makes room for a same-cycle push.
  always_comb begin
    data_ready = rst_n && !full && (state != FLUSH);
  end

  always_comb begin
    rgb_out = 8'h00;
    if (stream_req) begin
      rgb_out = pop ? mem[rd_ptr] : FALLBACK;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= data_in;
    end
  end

  // A bad frame keeps blanking until its end, even if the FIFO refills, then flushes and asks upstream to resync.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state        <= FILL;
      rd_ptr       <= '0;
      wr_ptr       <= '0;
      fifo_level   <= '0;
      pix_cnt      <= '0;
      frame_bad    <= 1'b0;
      underrun     <= 1'b0;
      underrun_cnt <= 8'h00;
      resync       <= 1'b0;
    end else begin
      resync     <= 1'b0;
      fifo_level <= level_next;
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      if (miss) begin
        frame_bad <= 1'b1;
        underrun  <= 1'b1;
        if (underrun_cnt != 8'hFF) begin
          underrun_cnt <= underrun_cnt + 1'b1;
        end
      end
      case (state)
        FILL: begin
          if (level_next >= LW'(PRELOAD)) begin
            state <= ARMED;
          end
        end
        ARMED: begin
          if (!vsync) begin
            state <= STREAM;
          end
        end
        STREAM: begin
          if (stream_req) begin
            if (frame_end) begin
              pix_cnt <= '0;
              if (frame_bad || miss) begin
                state  <= FLUSH;
                resync <= 1'b1;
              end
            end else begin
              pix_cnt <= pix_cnt + 1'b1;
            end
          end
        end
        FLUSH: begin
          rd_ptr     <= '0;
          wr_ptr     <= '0;
          fifo_level <= '0;
          frame_bad  <= 1'b0;
          state      <= FILL;
        end
        default: state <= FILL;
      endcase
    end
  end

endmodule

// File: tb/tb_vga_pixel_feed_ctrl.sv
// Randomised and directed bench for vga_pixel_feed_ctrl with a queue-based reference model and scoreboard.
module tb_vga_pixel_feed_ctrl;

  localparam int         DEPTH   = 16;
  localparam int         PRELOAD = 12;
  localparam int         PPF     = 16;
  localparam logic [7:0] FB      = 8'hE3;

  logic        clk;
  logic        rst_n;
  logic [7:0]  data_in;
  logic        data_valid;
  logic        data_ready;
  logic        pixel_req;
  logic        vsync;
  logic [7:0]  rgb_out;
  logic        resync;
  logic        streaming;
  logic        underrun;
  logic [7:0]  underrun_cnt;
  logic [4:0]  fifo_level;

  int tests  = 0;
  int failed = 0;

  typedef struct {
    bit         chk_all;
    logic       ready;
    logic [7:0] rgb;
    int         level;
    logic       strm;
    logic       rsy;
    logic       und;
    int         ucnt;
  } exp_t;

  exp_t exp_q[$];

  logic [7:0] m_q[$];
  int         m_mode = 0;
  int         m_pix  = 0;
  bit         m_bad  = 0;
  bit         m_und  = 0;
  int         m_cnt  = 0;

  vga_pixel_feed_ctrl #(
    .DEPTH(DEPTH), .PRELOAD(PRELOAD), .PIXELS_PER_FRAME(PPF), .FALLBACK(FB)
  ) dut (
    .clk(clk), .rst_n(rst_n), .data_in(data_in), .data_valid(data_valid),
    .data_ready(data_ready), .pixel_req(pixel_req), .vsync(vsync),
    .rgb_out(rgb_out), .resync(resync), .streaming(streaming),
    .underrun(underrun), .underrun_cnt(underrun_cnt), .fifo_level(fifo_level)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] expv);
    tests++;
    if (act !== expv) begin
      failed++;
      $display("[TB] FAIL %s at %0t: got %0h, expected %0h", name, $time, act, expv);
    end
  endtask

  task automatic apply_stimulus(input logic rstn, input logic dv, input logic [7:0] din,
                                input logic preq, input logic vs);
    rst_n      = rstn;
    data_valid = dv;
    data_in    = din;
    pixel_req  = preq;
    vsync      = vs;
    @(posedge clk);
    #1;
  endtask

  // Reference model: modes 0..3 are fill, armed, stream, flush; FIFO is a plain queue.
  task automatic model_cycle();
    exp_t e;
    bit   rdy;
    bit   pop;
    bit   miss;
    e.chk_all = 1'b0;
    e.ready   = 1'b0;
    e.rgb     = 8'h00;
    e.level   = 0;
    e.strm    = 1'b0;
    e.rsy     = 1'b0;
    e.und     = 1'b0;
    e.ucnt    = 0;
    if (!rst_n) begin
      exp_q.push_back(e);
      m_q.delete();
      m_mode = 0; m_pix = 0; m_bad = 0; m_und = 0; m_cnt = 0;
      return;
    end
    rdy       = (m_mode != 3) && (m_q.size() < DEPTH);
    e.chk_all = 1'b1;
    e.ready   = rdy;
    e.level   = m_q.size();
    e.strm    = (m_mode == 2);
    e.rsy     = (m_mode == 3);
    e.und     = m_und;
    e.ucnt    = m_cnt;
    pop  = 0;
    miss = 0;
    if (m_mode == 2 && pixel_req) begin
      if (m_bad) e.rgb = FB;
      else if (m_q.size() == 0) begin e.rgb = FB; miss = 1; end
      else begin e.rgb = m_q[0]; pop = 1; end
    end
    exp_q.push_back(e);
    if (pop) void'(m_q.pop_front());
    if (data_valid && rdy) m_q.push_back(data_in);
    if (miss) begin
      m_bad = 1; m_und = 1;
      if (m_cnt < 255) m_cnt++;
    end
    case (m_mode)
      0: if (m_q.size() >= PRELOAD) m_mode = 1;
      1: if (!vsync) m_mode = 2;
      2: if (pixel_req) begin
           if (m_pix == PPF - 1) begin
             m_pix = 0;
             if (m_bad) m_mode = 3;
           end else m_pix++;
         end
      default: begin m_q.delete(); m_bad = 0; m_mode = 0; end
    endcase
  endtask

  initial forever begin
    @(negedge clk);
    model_cycle();
  end

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check_output("data_ready", 32'(data_ready), 32'(e.ready));
        if (e.chk_all) begin
          check_output("rgb_out", 32'(rgb_out), 32'(e.rgb));
          check_output("fifo_level", 32'(fifo_level), 32'(e.level));
          check_output("streaming", 32'(streaming), 32'(e.strm));
          check_output("resync", 32'(resync), 32'(e.rsy));
          check_output("underrun", 32'(underrun), 32'(e.und));
          check_output("underrun_cnt", 32'(underrun_cnt), 32'(e.ucnt));
        end
      end
    end
  end

  initial begin
    repeat (2) apply_stimulus(0, 0, 8'h00, 0, 1);

    // Preload 0x01..0x0C, wait armed, then align to vsync
    for (int i = 1; i <= 12; i++) apply_stimulus(1, 1, 8'(i), 0, 1);
    repeat (3) apply_stimulus(1, 0, 8'h00, 1, 1);
    apply_stimulus(1, 0, 8'h00, 0, 0);
    repeat (2) apply_stimulus(1, 0, 8'h00, 0, 1);

    // One clean frame of 0x10..0x1F
    apply_stimulus(0, 0, 8'h00, 0, 1);
    for (int i = 0; i < 16; i++) apply_stimulus(1, 1, 8'(8'h10 + i), 0, 1);
    apply_stimulus(1, 0, 8'h00, 0, 0);
    for (int i = 0; i < 16; i++) apply_stimulus(1, 0, 8'h00, 1, 1);
    repeat (3) apply_stimulus(1, 0, 8'h00, 0, 1);

    // Underrun after five pixels of the next frame
    for (int i = 0; i < 5; i++) apply_stimulus(1, 1, 8'(8'h30 + i), 0, 1);
    for (int i = 0; i < 16; i++) apply_stimulus(1, 0, 8'h00, 1, 1);
    repeat (3) apply_stimulus(1, 0, 8'h00, 0, 1);

    // Fill to full, then push and request together while armed
    for (int i = 0; i < 16; i++) apply_stimulus(1, 1, 8'(8'h40 + i), 0, 1);
    repeat (3) apply_stimulus(1, 1, 8'h55, 1, 1);

    // Stream seven pixels, then reset with nine buffered
    apply_stimulus(1, 0, 8'h00, 0, 0);
    for (int i = 0; i < 7; i++) apply_stimulus(1, 0, 8'h00, 1, 1);
    apply_stimulus(0, 0, 8'h00, 0, 1);
    repeat (2) apply_stimulus(1, 0, 8'h00, 0, 1);

    // Force 260 underrun frames to saturate the counter
    for (int f = 0; f < 260; f++) begin
      for (int i = 0; i < 12; i++) apply_stimulus(1, 1, 8'($urandom), 0, 1);
      apply_stimulus(1, 0, 8'h00, 0, 0);
      for (int i = 0; i < 16; i++) apply_stimulus(1, 0, 8'h00, 1, 1);
      repeat (2) apply_stimulus(1, 0, 8'h00, 0, 1);
    end
    check_output("sat_cnt", 32'(underrun_cnt), 32'd255);

    // Random traffic with occasional resets
    apply_stimulus(0, 0, 8'h00, 0, 1);
    for (int c = 0; c < 3000; c++) begin
      apply_stimulus(($urandom_range(0, 199) != 0), ($urandom_range(0, 9) < 7),
                     8'($urandom), 1'($urandom_range(0, 1)), ($urandom_range(0, 19) != 0));
    end

    repeat (3) apply_stimulus(1, 0, 8'h00, 0, 1);
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
